// File: rtl/cpu8_pkg.sv
// ---------------------------------------------------------------------------
// cpu8_pkg
// Shared sizes and types for the 8-bit CPU writeback slice.
//
// Contents:
//   REG_AW     - register address width (8 architectural registers)
//   DATA_W     - datapath width
//   NUM_REGS   - number of architectural registers (r0 is hardwired zero)
//   wb_state_t - writeback FSM states
//   regMask    - one-hot decode of a register address, r0 decodes to nothing
// ---------------------------------------------------------------------------
package cpu8_pkg;

  localparam int REG_AW   = 3;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    LOAD_WAIT = 2'd2
  } wb_state_t;

  // r0 can never be written or marked pending, so it decodes to an empty mask.
  function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (addr != '0) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Pending-write scoreboard: one bit per register that is set when decode
// issues an instruction targeting it and cleared when writeback lands.
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset
//   issue_valid_i  - decode issues an instruction with a destination
//   issue_addr_i   - destination register of that instruction
//   wr_en_i        - register-file write in progress this cycle
//   wr_addr_i      - register being written
//   busy_o         - pending-write bits, bit 0 always 0
// ---------------------------------------------------------------------------
module wb_scoreboard
  import cpu8_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   issue_addr_i,
  input  logic                wr_en_i,
  input  logic [REG_AW-1:0]   wr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busyNext;

  // Build the set and clear masks for this cycle. The clear is applied first
  // and the set OR'd on top, so a same-register issue and completion leaves
  // the bit set: the new producer is still outstanding. A single bit per
  // register is enough because decode stalls on busy registers.
  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    w_busyNext = r_busy;
    if (issue_valid_i) begin
      w_set = regMask(issue_addr_i);
    end
    if (wr_en_i) begin
      w_clr = regMask(wr_addr_i);
    end
    w_busyNext = (r_busy & ~w_clr) | w_set;
  end

  // Scoreboard register, cleared by reset ahead of any set or clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage: accepts results from the memory stage, waits for load data
// when needed, drives the register-file write port for one cycle per result
// and tracks pending destination registers in a scoreboard.
//
// Parameter:
//   LOAD_LAT        - wait cycles between load acceptance and data capture (1..3)
//
// Ports:
//   clk_i           - clock, rising edge
//   rst_i           - synchronous active-high reset
//   issue_valid_i   - decode issues an instruction with a destination
//   issue_addr_i    - destination of the issued instruction
//   mem_valid_i     - memory stage offers a result
//   mem_addr_i      - destination register of the offer
//   mem_is_load_i   - offer is a load (data arrives later)
//   mem_alu_data_i  - result data for non-load offers
//   mem_load_data_i - load data, valid in the final wait cycle
//   mem_ready_o     - offer accepted this cycle when mem_valid_i is high
//   wr_en_o         - register-file write enable (sampled on falling edge)
//   wr_addr_o       - register-file write address
//   wr_data_o       - register-file write data
//   busy_o          - pending-write scoreboard, bit 0 always 0
//
// Build option:
//   WB_BYPASS_EN    - adds byp_valid_o/byp_addr_o/byp_data_o, a copy of the
//                     write port so execute can forward ahead of the write
// ---------------------------------------------------------------------------
module wb_stage
  import cpu8_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   issue_addr_i,
  input  logic                mem_valid_i,
  input  logic [REG_AW-1:0]   mem_addr_i,
  input  logic                mem_is_load_i,
  input  logic [DATA_W-1:0]   mem_alu_data_i,
  input  logic [DATA_W-1:0]   mem_load_data_i,
  output logic                mem_ready_o,
  output logic                wr_en_o,
  output logic [REG_AW-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [NUM_REGS-1:0] busy_o
`ifdef WB_BYPASS_EN
  ,
  output logic                byp_valid_o,
  output logic [REG_AW-1:0]   byp_addr_o,
  output logic [DATA_W-1:0]   byp_data_o
`endif
);

  localparam logic [1:0] LOAD_LAT_CNT = 2'(LOAD_LAT);

  wb_state_t         r_state;
  wb_state_t         w_nextState;
  logic [1:0]        r_waitCnt;
  logic [REG_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_ready;
  logic              w_wrEn;
  logic              w_accept;
  logic              w_lastWait;

  assign w_accept   = mem_valid_i & w_ready;
  assign w_lastWait = (r_state == LOAD_WAIT) && (r_waitCnt == 2'd1);

  // State register; reset abandons any load still waiting for its data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. IDLE and WRITE behave identically towards new offers,
  // which is what lets back-to-back ALU results stream one per cycle.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, WRITE: begin
        if (w_accept) begin
          w_nextState = mem_is_load_i ? LOAD_WAIT : WRITE;
        end else begin
          w_nextState = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (w_lastWait) begin
          w_nextState = WRITE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic. A write to r0 still walks through WRITE but never raises
  // the enable, so it disappears without the register file seeing it.
  always_comb begin
    w_ready = 1'b1;
    w_wrEn  = 1'b0;
    unique case (r_state)
      IDLE:      w_ready = 1'b1;
      WRITE: begin
        w_ready = 1'b1;
        w_wrEn  = (r_addr != '0);
      end
      LOAD_WAIT: w_ready = 1'b0;
      default:   w_ready = 1'b1;
    endcase
  end

  // Load wait counter: loaded on load acceptance, counts down while waiting.
  // Data is captured on the edge where it reads 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_waitCnt <= '0;
    end else if (w_accept && mem_is_load_i) begin
      r_waitCnt <= LOAD_LAT_CNT;
    end else if (r_state == LOAD_WAIT) begin
      r_waitCnt <= r_waitCnt - 2'd1;
    end
  end

  // Address/data latches. These feed the write port directly, so they stay
  // stable for the whole WRITE cycle. ALU data is taken at acceptance; load
  // data only at the end of the final wait cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_addr <= mem_addr_i;
      if (!mem_is_load_i) begin
        r_data <= mem_alu_data_i;
      end
    end else if (w_lastWait) begin
      r_data <= mem_load_data_i;
    end
  end

  assign mem_ready_o = w_ready;
  assign wr_en_o     = w_wrEn;
  assign wr_addr_o   = r_addr;
  assign wr_data_o   = r_data;

`ifdef WB_BYPASS_EN
  assign byp_valid_o = w_wrEn;
  assign byp_addr_o  = r_addr;
  assign byp_data_o  = r_data;
`endif

  wb_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .wr_en_i       (w_wrEn),
    .wr_addr_i     (r_addr),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Bench for wb_stage with LOAD_LAT = 2. A cycle-indexed reference model
// tracks when each accepted result must appear on the write port, when the
// stage must refuse offers, and the pending-register set.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int LAT = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       issue_valid_i;
  logic [2:0] issue_addr_i;
  logic       mem_valid_i;
  logic [2:0] mem_addr_i;
  logic       mem_is_load_i;
  logic [7:0] mem_alu_data_i;
  logic [7:0] mem_load_data_i;
  logic       mem_ready_o;
  logic       wr_en_o;
  logic [2:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [7:0] busy_o;
`ifdef WB_BYPASS_EN
  logic       byp_valid_o;
  logic [2:0] byp_addr_o;
  logic [7:0] byp_data_o;
`endif

  wb_stage #(.LOAD_LAT(LAT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_addr_i    (issue_addr_i),
    .mem_valid_i     (mem_valid_i),
    .mem_addr_i      (mem_addr_i),
    .mem_is_load_i   (mem_is_load_i),
    .mem_alu_data_i  (mem_alu_data_i),
    .mem_load_data_i (mem_load_data_i),
    .mem_ready_o     (mem_ready_o),
    .wr_en_o         (wr_en_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .busy_o          (busy_o)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid_o     (byp_valid_o),
    .byp_addr_o      (byp_addr_o),
    .byp_data_o      (byp_data_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state, indexed by absolute cycle number.
  int         cycle;
  int         readyFromCycle;
  int         loadCaptureCycle;
  bit         loadPending;
  logic [2:0] loadAddr;
  bit         expReady;
  bit         expWrEn;
  logic [2:0] expWrAddr;
  logic [7:0] expWrData;
  bit         expZeroBus;
  bit         expBusy [8];
  logic [7:0] regFile [8];
  int         wrPulses;
  int         strayWrites;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               tag, cycle, observed, expected);
    end
  endtask

  function automatic logic [7:0] busyVector();
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = expBusy[r];
    return v;
  endfunction

  // Drive one cycle of inputs, compare this cycle's outputs with the model,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [2:0] ia,
                               input logic mv, input logic [2:0] ma, input logic ml,
                               input logic [7:0] md, input logic [7:0] ld);
    bit         accepted;
    bit         nextEn;
    logic [2:0] nextAddr;
    logic [7:0] nextData;
    rst_i           = rst;
    issue_valid_i   = iv;
    issue_addr_i    = ia;
    mem_valid_i     = mv;
    mem_addr_i      = ma;
    mem_is_load_i   = ml;
    mem_alu_data_i  = md;
    mem_load_data_i = ld;
    #1;
    checkOutput("mem_ready", mem_ready_o, expReady);
    checkOutput("wr_en", wr_en_o, expWrEn);
    if (expWrEn || expZeroBus) begin
      checkOutput("wr_addr", wr_addr_o, expWrAddr);
      checkOutput("wr_data", wr_data_o, expWrData);
    end
    checkOutput("busy", busy_o, busyVector());
`ifdef WB_BYPASS_EN
    checkOutput("byp_valid", byp_valid_o, expWrEn);
    if (expWrEn) begin
      checkOutput("byp_addr", byp_addr_o, expWrAddr);
      checkOutput("byp_data", byp_data_o, expWrData);
    end
`endif
    // The register file samples the write port on the falling edge.
    if (wr_en_o) begin
      regFile[wr_addr_o] = wr_data_o;
      wrPulses++;
    end

    accepted = mv && expReady;
    nextEn   = 1'b0;
    nextAddr = expWrAddr;
    nextData = expWrData;
    // Completion clears first, a same-cycle issue then re-marks the register.
    if (expWrEn) expBusy[expWrAddr] = 1'b0;
    if (iv && ia != 3'd0) expBusy[ia] = 1'b1;
    if (accepted && !ml) begin
      nextEn   = (ma != 3'd0);
      nextAddr = ma;
      nextData = md;
    end else if (accepted && ml) begin
      loadPending      = 1'b1;
      loadAddr         = ma;
      loadCaptureCycle = cycle + LAT;
      readyFromCycle   = cycle + LAT + 1;
    end else if (loadPending && cycle == loadCaptureCycle) begin
      loadPending = 1'b0;
      nextEn      = (loadAddr != 3'd0);
      nextAddr    = loadAddr;
      nextData    = ld;
    end
    expZeroBus = 1'b0;
    if (rst) begin
      loadPending    = 1'b0;
      readyFromCycle = 0;
      nextEn         = 1'b0;
      nextAddr       = '0;
      nextData       = '0;
      expZeroBus     = 1'b1;
      for (int r = 0; r < 8; r++) expBusy[r] = 1'b0;
    end
    cycle++;
    expReady  = (cycle >= readyFromCycle);
    expWrEn   = nextEn;
    expWrAddr = nextAddr;
    expWrData = nextData;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idleCycle(input logic [7:0] ld);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, ld);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      expBusy[r] = 1'b0;
      regFile[r] = 8'h00;
    end
    wrPulses    = 0;
    strayWrites = 0;
    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_addr_i = '0;
    mem_valid_i = 1'b0; mem_addr_i = '0; mem_is_load_i = 1'b0;
    mem_alu_data_i = '0; mem_load_data_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    cycle = 0; readyFromCycle = 0; loadCaptureCycle = 0; loadPending = 1'b0;
    loadAddr = '0; expReady = 1'b1; expWrEn = 1'b0; expWrAddr = '0;
    expWrData = '0; expZeroBus = 1'b1;

    // ALU result to r3 lands the very next cycle.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 8'h5A, 8'h00);
    idleCycle(8'h00);
    idleCycle(8'h00);
    checkOutput("rf_r3", regFile[3], 8'h5A);

    // Load to r5: offers refused for LAT cycles, data sampled in the last one.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 8'h00, 8'h00);
    for (int i = 1; i <= LAT; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 8'hEE,
                    (i == LAT) ? 8'hC3 : 8'h11);
    end
    idleCycle(8'h00);
    idleCycle(8'h00);
    checkOutput("rf_r5", regFile[5], 8'hC3);
    checkOutput("rf_r6_untouched", regFile[6], 8'h00);

    // Three ALU results back to back, three write pulses with no gap.
    wrPulses = 0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 8'h11, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 8'h22, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 8'h77, 8'h00);
    idleCycle(8'h00);
    idleCycle(8'h00);
    checkOutput("burst_pulses", wrPulses, 3);
    checkOutput("rf_r7", regFile[7], 8'h77);

    // Writes to r0 vanish.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 8'hFF, 8'h00);
    idleCycle(8'h00);
    checkOutput("r0_busy", busy_o, 8'h00);
    checkOutput("rf_r0", regFile[0], 8'h00);

    // Issue r4, then complete r4 in the same cycle as a fresh issue of r4.
    applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 8'h44, 8'h00);
    applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("busy4_kept", busy_o[4], 1'b1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 8'h45, 8'h00);
    idleCycle(8'h00);
    checkOutput("busy4_cleared", busy_o[4], 1'b0);

    // Reset in the middle of a load wait discards the load.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h99);
    checkOutput("rst_ready", mem_ready_o, 1'b1);
    checkOutput("rst_wr_en", wr_en_o, 1'b0);
    checkOutput("rst_wr_addr", wr_addr_o, 3'd0);
    checkOutput("rst_wr_data", wr_data_o, 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (wr_en_o && wr_addr_o == 3'd6) strayWrites++;
      idleCycle(8'h99);
    end
    checkOutput("dropped_load", strayWrites, 0);
    checkOutput("rf_r6_after_rst", regFile[6], 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 3), 8'($urandom),
                    8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter LOAD_LAT, default 1, meaning the number of wait cycles between load acceptance and load-data capture (legal range 1..3).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port issue_valid_i, input, 1 bit: decode issues an instruction that has a destination register.
REQ-005 The block SHALL have port issue_addr_i, input, 3 bits: destination register of the issued instruction.
REQ-006 The block SHALL have ports mem_valid_i (input, 1), mem_addr_i (input, 3), mem_is_load_i (input, 1) and mem_alu_data_i (input, 8): the result offered by the memory stage.
REQ-007 The block SHALL have port mem_load_data_i, input, 8 bits: load data, valid in the final LOAD_WAIT cycle.
REQ-008 The block SHALL have port mem_ready_o, output, 1 bit: the stage accepts an offer this cycle.
REQ-009 The block SHALL have ports wr_en_o (output, 1), wr_addr_o (output, 3) and wr_data_o (output, 8): the register-file write port, which the register file samples on the falling edge.
REQ-010 The block SHALL have port busy_o, output, 8 bits: pending-write scoreboard, with bit 0 always 0.

Function
REQ-011 An offer SHALL be accepted on any rising edge where mem_valid_i=1 and mem_ready_o=1.
REQ-012 The FSM SHALL have exactly three states: IDLE, WRITE and LOAD_WAIT.
REQ-013 From IDLE or WRITE, an accepted ALU offer SHALL latch mem_addr_i and mem_alu_data_i and go to WRITE.
REQ-014 From IDLE or WRITE, an accepted load offer SHALL latch mem_addr_i, load the wait counter with LOAD_LAT and go to LOAD_WAIT.
REQ-015 From IDLE or WRITE, with no accepted offer, the FSM SHALL go to IDLE.
REQ-016 In LOAD_WAIT the counter SHALL decrement each cycle; at counter=1 the block SHALL capture mem_load_data_i and go to WRITE.
REQ-017 mem_ready_o SHALL be 1 in IDLE and WRITE and 0 in LOAD_WAIT.
REQ-018 ALU latency: an offer accepted at edge N SHALL give wr_en_o=1 during cycle N to N+1.
REQ-019 Load latency: wr_en_o SHALL assert exactly LOAD_LAT+1 cycles after acceptance.
REQ-020 wr_en_o SHALL be 1 only in WRITE with latched addr≠0; a write to address 0 SHALL be dropped silently (FSM still passes through WRITE).
REQ-021 wr_en_o SHALL be held for exactly one cycle per accepted offer, with wr_addr_o and wr_data_o stable while it is high.
REQ-022 Back-to-back ALU offers SHALL sustain one write per cycle with no bubble.
REQ-023 A busy bit SHALL set at the end of any cycle with issue_valid_i=1 and issue_addr_i≠0.
REQ-024 A busy bit SHALL clear at the end of any cycle with wr_en_o=1 and wr_addr_o equal to that register.
REQ-025 If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-026 An issue to an already-busy register SHALL leave the bit set (single bit, no count); decode stalls on busy.

Reset
REQ-027 With rst_i=1 at an edge: FSM→IDLE, counter=0, latches=0, busy_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0.
REQ-028 Reset SHALL take priority over every other event, including mid-LOAD_WAIT, where the pending write is discarded and never issued.
REQ-029 mem_ready_o SHALL be 1 in the cycle after reset.

Configuration
REQ-030 With WB_BYPASS_EN defined, the block SHALL add outputs byp_valid_o (1), byp_addr_o (3) and byp_data_o (8), equal to wr_en_o, wr_addr_o and wr_data_o, so execute can forward before the register-file write lands.
REQ-031 With WB_BYPASS_EN undefined, those ports and their logic SHALL be absent and the behaviour otherwise identical.

Structure
REQ-032 Package cpu8_pkg SHALL hold REG_AW=3, DATA_W=8, NUM_REGS=8 and the wb_state_t enum {IDLE, WRITE, LOAD_WAIT}.
REQ-033 The scoreboard (REQ-023..REQ-026) SHALL be the sub-module wb_scoreboard; the FSM, counter and latches stay in wb_stage.

Verification
REQ-034 ALU offer addr=3, data=0x5A at edge N: wr_en_o=1, wr_addr_o=3, wr_data_o=0x5A during N..N+1; the register file then holds 0x5A in r3.
REQ-035 LOAD_LAT=2, load offer addr=5 with mem_load_data_i=0xC3 in the last wait cycle: mem_ready_o=0 for 2 cycles, then one write of 0xC3 to r5.
REQ-036 ALU offers to r1, r2, r7 on consecutive cycles: three consecutive wr_en_o pulses, no bubbles.
REQ-037 Offer addr=0, data=0xFF: wr_en_o stays 0 and busy_o stays 0x00.
REQ-038 Issue r4, then complete r4 while issuing r4 in the same cycle: busy_o[4] remains 1 until the second writeback completes.
REQ-039 rst_i=1 during LOAD_WAIT: next cycle all outputs are 0 except mem_ready_o=1, and no write ever occurs for the dropped load.
